// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage: instruction-fetch stage with a registered IF/ID pipeline register.
//
// Issues one fetch request per cycle to instruction memory. A returned word
// goes to IF/ID when the stage may advance. If the stage is stalled, the word
// is parked in a one-entry buffer instead. Branch redirects from ID (PCSrc)
// are always honoured. A redirect that arrives while a request is
// outstanding is deferred until that request's acknowledge. The stale word is
// dropped, so imem_addr never changes under an open request.
//
// Ports
//   clk             clock, all state on rising edge
//   rst             asynchronous active-low reset
//   PCWrite         1 = PC may advance (hazard unit)
//   freeze          1 = hold IF/ID contents
//   PCSrc           1 = taken branch in ID, redirect to Branch_Address
//   Branch_Address  branch target from ID
//   imem_req        instruction-memory request (registered)
//   imem_addr       fetch address, equals PC
//   imem_ack        memory returns imem_rdata this cycle
//   imem_rdata      fetched instruction word
//   Instruction     IF/ID: instruction to ID
//   Next_Address    IF/ID: PC+4 of that instruction
//   if_valid        IF/ID holds a real instruction (0 = bubble)
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        freeze,
    input  logic        PCSrc,
    input  logic [31:0] Branch_Address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [31:0] Next_Address,
    output logic        if_valid
);

    typedef enum logic {StFetch, StHold} state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] redirect_q, redirect_d;
    logic [31:0] buffer_q, buffer_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] next_addr_q, next_addr_d;
    logic        valid_q, valid_d;

    logic        advance;
    logic        ack;
    logic [31:0] pc_plus4;

    assign advance  = PCWrite && !freeze && !PCSrc;
    // An acknowledge only counts while our request is actually out.
    assign ack      = imem_ack && req_q;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        redirect_d  = redirect_q;
        buffer_d    = buffer_q;
        instr_d     = instr_q;
        next_addr_d = next_addr_q;
        valid_d     = valid_q;

        unique case (state_q)
            StFetch: begin
                if (!req_q) begin
                    // First cycle out of reset: nothing outstanding yet, so a
                    // redirect can be applied to the PC directly.
                    if (PCSrc) begin
                        pc_d    = Branch_Address;
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end else if (PCSrc) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    if (ack) begin
                        pc_d   = Branch_Address;
                        kill_d = 1'b0;
                    end else begin
                        // Keep imem_addr stable; apply target on the ack.
                        redirect_d = Branch_Address;
                        kill_d     = 1'b1;
                    end
                end else if (ack && kill_q) begin
                    pc_d   = redirect_q;
                    kill_d = 1'b0;
                    if (!freeze) begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end else if (ack) begin
                    if (advance) begin
                        instr_d     = imem_rdata;
                        next_addr_d = pc_plus4;
                        valid_d     = 1'b1;
                        pc_d        = pc_plus4;
                    end else begin
                        buffer_d = imem_rdata;
                        state_d  = StHold;
                    end
                end else if (!freeze) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end

            StHold: begin
                if (PCSrc) begin
                    pc_d    = Branch_Address;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    state_d = StFetch;
                end else if (advance) begin
                    instr_d     = buffer_q;
                    next_addr_d = pc_plus4;
                    valid_d     = 1'b1;
                    pc_d        = pc_plus4;
                    state_d     = StFetch;
                end
            end

            default: state_d = StFetch;
        endcase

        req_d = (state_d == StFetch);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StFetch;
            req_q       <= 1'b0;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            redirect_q  <= 32'h0;
            buffer_q    <= 32'h0;
            instr_q     <= NOP_INSTR;
            next_addr_q <= 32'h0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            redirect_q  <= redirect_d;
            buffer_q    <= buffer_d;
            instr_q     <= instr_d;
            next_addr_q <= next_addr_d;
            valid_q     <= valid_d;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = pc_q;
    assign Instruction  = instr_q;
    assign Next_Address = next_addr_q;
    assign if_valid     = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage: directed scenarios followed by randomized traffic checked
// against a behavioural model of the fetch stage.
// ---------------------------------------------------------------------------
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite;
    logic        freeze;
    logic        PCSrc;
    logic [31:0] Branch_Address;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] Instruction;
    logic [31:0] Next_Address;
    logic        if_valid;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic [31:0] w_next;
    logic        w_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_stage u_dut (
        .clk            (clk),
        .rst            (rst),
        .PCWrite        (PCWrite),
        .freeze         (freeze),
        .PCSrc          (PCSrc),
        .Branch_Address (Branch_Address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .Instruction    (Instruction),
        .Next_Address   (Next_Address),
        .if_valid       (if_valid)
    );

    // Second copy starting near the top of the address space.
    if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .PCWrite        (PCWrite),
        .freeze         (freeze),
        .PCSrc          (PCSrc),
        .Branch_Address (Branch_Address),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .Instruction    (w_instr),
        .Next_Address   (w_next),
        .if_valid       (w_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pcw, input logic frz, input logic psrc,
                         input logic [31:0] ba, input logic ack, input logic [31:0] rd);
        PCWrite        = pcw;
        freeze         = frz;
        PCSrc          = psrc;
        Branch_Address = ba;
        imem_ack       = ack;
        imem_rdata     = rd;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] ins,
                              input logic [31:0] na, input logic v);
        check({tag, "_instr"}, Instruction, ins);
        check({tag, "_next"}, Next_Address, na);
        check({tag, "_valid"}, {31'b0, if_valid}, {31'b0, v});
    endtask

    task automatic check_fetch(input string tag, input logic rq, input logic [31:0] ad);
        check({tag, "_req"}, {31'b0, imem_req}, {31'b0, rq});
        check({tag, "_addr"}, imem_addr, ad);
    endtask

    // Reset, release, and stop one cycle later with the first request out.
    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_fetch("rst_rel", 1'b1, 32'h0);
    endtask

    // ---------------- behavioural reference model ----------------
    logic        m_req;
    logic [31:0] m_pc;
    logic        m_parked;       // fetched word waiting for the pipe to move
    logic [31:0] m_park_word;
    logic        m_pending;      // branch target waiting for the open fetch
    logic [31:0] m_target;
    logic [31:0] m_instr;
    logic [31:0] m_na;
    logic        m_valid;

    task automatic model_reset();
        m_req = 1'b0; m_pc = 32'h0; m_parked = 1'b0; m_park_word = 32'h0;
        m_pending = 1'b0; m_target = 32'h0;
        m_instr = 32'h0; m_na = 32'h0; m_valid = 1'b0;
    endtask

    task automatic model_bubble();
        m_instr = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_issue(input logic [31:0] word);
        m_instr = word;
        m_na    = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
    endtask

    // Apply the inputs currently driven as the effect of one rising edge.
    task automatic model_edge();
        logic adv;
        logic got;
        adv = PCWrite && !freeze && !PCSrc;
        got = imem_ack && m_req;
        if (m_parked) begin
            if (PCSrc) begin
                m_pc = Branch_Address; m_parked = 1'b0; model_bubble();
            end else if (adv) begin
                model_issue(m_park_word); m_parked = 1'b0;
            end
        end else if (!m_req) begin
            if (PCSrc) begin
                m_pc = Branch_Address; model_bubble();
            end
        end else if (PCSrc) begin
            model_bubble();
            if (got) begin
                m_pc = Branch_Address; m_pending = 1'b0;
            end else begin
                m_pending = 1'b1; m_target = Branch_Address;
            end
        end else if (got && m_pending) begin
            m_pc = m_target; m_pending = 1'b0;
            if (!freeze) model_bubble();
        end else if (got) begin
            if (adv) model_issue(imem_rdata);
            else begin
                m_parked = 1'b1; m_park_word = imem_rdata;
            end
        end else if (!freeze) begin
            model_bubble();
        end
        m_req = !m_parked;
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;

        // Reset with acknowledges toggling: all outputs at reset values.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_ack   = i[0];
            imem_rdata = 32'hBAD0_0000 + i;
            #1;
            check_fetch("rst_hold", 1'b0, 32'h0);
            check_ifid("rst_hold", 32'h0, 32'h0, 1'b0);
            check("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
            tick();
        end
        // Release with a stray ack present: it must be ignored.
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_1234;
        rst        = 1'b1;
        tick();
        check_fetch("rst_first", 1'b1, 32'h0);
        check_ifid("rst_first", 32'h0, 32'h0, 1'b0);
        check("rst_wrap_first", w_addr, 32'hFFFF_FFFC);

        // Zero-wait stream, including wrap-around on the second copy.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2008_0005);
        tick();
        check_ifid("zw0", 32'h2008_0005, 32'd4, 1'b1);
        check_fetch("zw0", 1'b1, 32'd4);
        check("wrap_next", w_next, 32'h0);
        check("wrap_addr", w_addr, 32'h0);
        check("wrap_instr", w_instr, 32'h2008_0005);
        imem_rdata = 32'h2009_0003;
        tick();
        check_ifid("zw1", 32'h2009_0003, 32'd8, 1'b1);
        imem_rdata = 32'h0109_5020;
        tick();
        check_ifid("zw2", 32'h0109_5020, 32'd12, 1'b1);
        check_fetch("zw2", 1'b1, 32'd12);

        // Stall when the word at address 8 returns.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_0000);
        tick();
        imem_rdata = 32'h1111_0004;
        tick();
        check_fetch("st_pre", 1'b1, 32'd8);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8C0A_0004);
        tick();
        check_fetch("st_hold", 1'b0, 32'd8);
        check_ifid("st_hold", 32'h1111_0004, 32'd8, 1'b1);
        imem_rdata = 32'hFFFF_FFFF;
        tick();
        check_fetch("st_hold2", 1'b0, 32'd8);
        check_ifid("st_hold2", 32'h1111_0004, 32'd8, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        check_ifid("st_rel", 32'h8C0A_0004, 32'd12, 1'b1);
        check_fetch("st_rel", 1'b1, 32'd12);

        // Branch during a three-cycle wait at address 0x10.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3000_0000 + i);
            tick();
        end
        check_fetch("br_pre", 1'b1, 32'h10);
        drive(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        tick();
        check_fetch("br_w1", 1'b1, 32'h10);
        check_ifid("br_w1", 32'h0, 32'h10, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h999, 1'b0, 32'h0);
        tick();
        check_fetch("br_w2", 1'b1, 32'h10);
        tick();
        check_fetch("br_w3", 1'b1, 32'h10);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        check_ifid("br_ack", 32'h0, 32'h10, 1'b0);
        check_fetch("br_ack", 1'b1, 32'h40);
        imem_rdata = 32'h1111_1111;
        tick();
        check_ifid("br_tgt", 32'h1111_1111, 32'h44, 1'b1);

        // Branch while holding a parked word, with freeze still asserted.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0001);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hAAAA_AAAA);
        tick();
        check_fetch("hb_hold", 1'b0, 32'd4);
        drive(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
        tick();
        check_fetch("hb_br", 1'b1, 32'h100);
        check_ifid("hb_br", 32'h0, 32'd4, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0005);
        tick();
        check_ifid("hb_tgt", 32'h0000_0005, 32'h104, 1'b1);

        // Randomized traffic against the model, with occasional resets.
        do_reset();
        model_reset();
        m_req = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                rst      = 1'b0;
                imem_ack = $urandom_range(0, 1) == 1;
                #2;
                model_reset();
                check_fetch("rnd_rst", m_req, m_pc);
                check_ifid("rnd_rst", m_instr, m_na, m_valid);
                @(posedge clk);
                #1;
                rst = 1'b1;
            end
            PCWrite        = $urandom_range(0, 99) < 80;
            freeze         = $urandom_range(0, 99) < 20;
            PCSrc          = $urandom_range(0, 99) < 10;
            Branch_Address = $urandom;
            imem_ack       = $urandom_range(0, 99) < 60;
            imem_rdata     = word_at(m_pc);
            model_edge();
            tick();
            check_fetch("rnd", m_req, m_pc);
            check_ifid("rnd", m_instr, m_na, m_valid);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
